// File: rtl/id_ex_issue.sv
// id_ex_issue: ID/EX pipeline stage directly upstream of the ALU.
//
// Holds one decoded instruction and presents its operands and opcode to the
// ALU over a valid/ready handshake. RAW hazards against the EX/MEM and MEM/WB
// writers are resolved by forwarding onto the held source indices. A load
// sitting in this stage whose destination the incoming instruction reads
// blocks acceptance (load-use). Each such blocked cycle with an instruction
// waiting is counted in a saturating counter.
//
// Build option FWD_EN:
//   defined   - forwarding muxes active; only load-use stalls.
//   undefined - no forwarding; any pending writer (this stage, EX/MEM,
//               MEM/WB) of a register the incoming instruction reads stalls it.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   in_valid / in_ready       upstream handshake (in_ready is not a function of in_valid)
//   in_rs1/2, in_rs1/2_data   source indices and register-file read data
//   in_imm, in_use_imm        immediate and select (src2 = imm when set)
//   in_alu_type, in_rd        opcode and destination index
//   in_is_load                instruction is a load
//   flush                     kill held instruction, refuse same-cycle input
//   exm_wen/rd/data           EX/MEM writer
//   mwb_wen/rd/data           MEM/WB writer
//   out_valid / out_ready     downstream handshake to the ALU
//   src1, src2, ALUType       ALU operands (post-forwarding) and opcode
//   out_rd, out_is_load       travel with the result
//   stall_cnt                 saturating count of stall cycles

module id_ex_issue #(
    parameter int DataSize     = 32,
    parameter int ALUopSize    = 4,
    parameter int RegAddrSize  = 5,
    parameter int StallCntSize = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RegAddrSize-1:0]  in_rs1,
    input  logic [RegAddrSize-1:0]  in_rs2,
    input  logic [DataSize-1:0]     in_rs1_data,
    input  logic [DataSize-1:0]     in_rs2_data,
    input  logic [DataSize-1:0]     in_imm,
    input  logic                    in_use_imm,
    input  logic [ALUopSize-1:0]    in_alu_type,
    input  logic [RegAddrSize-1:0]  in_rd,
    input  logic                    in_is_load,
    input  logic                    flush,
    input  logic                    exm_wen,
    input  logic [RegAddrSize-1:0]  exm_rd,
    input  logic [DataSize-1:0]     exm_data,
    input  logic                    mwb_wen,
    input  logic [RegAddrSize-1:0]  mwb_rd,
    input  logic [DataSize-1:0]     mwb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DataSize-1:0]     src1,
    output logic [DataSize-1:0]     src2,
    output logic [ALUopSize-1:0]    ALUType,
    output logic [RegAddrSize-1:0]  out_rd,
    output logic                    out_is_load,
    output logic [StallCntSize-1:0] stall_cnt
);

    localparam logic [ALUopSize-1:0] AluNdef = ALUopSize'(8);

    logic [RegAddrSize-1:0] held_rs1;
    logic [RegAddrSize-1:0] held_rs2;
    logic [DataSize-1:0]    held_rs1_data;
    logic [DataSize-1:0]    held_rs2_data;
    logic [DataSize-1:0]    held_imm;
    logic                   held_use_imm;
    logic                   hazard;
    logic                   capture;

    // True when writer index r is a nonzero register the incoming
    // instruction actually reads (rs2 is ignored for immediate forms).
    function automatic logic reads_reg(
        input logic [RegAddrSize-1:0] r,
        input logic [RegAddrSize-1:0] rs1,
        input logic [RegAddrSize-1:0] rs2,
        input logic                   use_imm
    );
        return (r != '0) && ((r == rs1) || (!use_imm && (r == rs2)));
    endfunction

`ifdef FWD_EN
    // Only a load in this stage cannot be forwarded in time.
    assign hazard = out_valid && out_is_load &&
                    reads_reg(out_rd, in_rs1, in_rs2, in_use_imm);
`else
    // Without forwarding the register file must be written before reading.
    assign hazard = (out_valid && reads_reg(out_rd, in_rs1, in_rs2, in_use_imm)) ||
                    (exm_wen   && reads_reg(exm_rd, in_rs1, in_rs2, in_use_imm)) ||
                    (mwb_wen   && reads_reg(mwb_rd, in_rs1, in_rs2, in_use_imm));
`endif

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            ALUType       <= AluNdef;
            out_rd        <= '0;
            out_is_load   <= 1'b0;
            held_rs1      <= '0;
            held_rs2      <= '0;
            held_rs1_data <= '0;
            held_rs2_data <= '0;
            held_imm      <= '0;
            held_use_imm  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ALUType   <= AluNdef;
        end else if (capture) begin
            out_valid     <= 1'b1;
            ALUType       <= in_alu_type;
            out_rd        <= in_rd;
            out_is_load   <= in_is_load;
            held_rs1      <= in_rs1;
            held_rs2      <= in_rs2;
            held_rs1_data <= in_rs1_data;
            held_rs2_data <= in_rs2_data;
            held_imm      <= in_imm;
            held_use_imm  <= in_use_imm;
        end else if (out_valid && out_ready) begin
            // consumed with nothing behind it: bubble
            out_valid <= 1'b0;
            ALUType   <= AluNdef;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + StallCntSize'(1);
        end
    end

`ifdef FWD_EN
    // Re-evaluated every cycle so a held instruction picks up writers that
    // arrive while it waits on out_ready. EX/MEM is younger, so it wins.
    always_comb begin
        src1 = held_rs1_data;
        if (held_rs1 != '0 && exm_wen && exm_rd == held_rs1) begin
            src1 = exm_data;
        end else if (held_rs1 != '0 && mwb_wen && mwb_rd == held_rs1) begin
            src1 = mwb_data;
        end

        src2 = held_rs2_data;
        if (held_use_imm) begin
            src2 = held_imm;
        end else if (held_rs2 != '0 && exm_wen && exm_rd == held_rs2) begin
            src2 = exm_data;
        end else if (held_rs2 != '0 && mwb_wen && mwb_rd == held_rs2) begin
            src2 = mwb_data;
        end
    end
`else
    assign src1 = held_rs1_data;
    assign src2 = held_use_imm ? held_imm : held_rs2_data;

    // Forwarding inputs and held indices have no consumer in this build.
    logic unused_fwd;
    assign unused_fwd = ^{held_rs1, held_rs2, exm_data, mwb_data};
`endif

endmodule

// File: tb/tb_id_ex_issue.sv
// Testbench for id_ex_issue: directed per-cycle vectors, a behavioural model
// of the stage (held-instruction record, pending-writer list, saturating
// counter) compared every cycle, plus hand-computed literal expectations.
// Works for either build of FWD_EN.

module tb_id_ex_issue;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic [DW-1:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
    logic          in_use_imm = 1'b0;
    logic [AW-1:0] in_alu_type = '0;
    logic          in_is_load = 1'b0;
    logic          flush = 1'b0;
    logic          exm_wen = 1'b0, mwb_wen = 1'b0;
    logic [RW-1:0] exm_rd = '0, mwb_rd = '0;
    logic [DW-1:0] exm_data = '0, mwb_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] src1, src2;
    logic [AW-1:0] ALUType;
    logic [RW-1:0] out_rd;
    logic          out_is_load;
    logic [CW-1:0] stall_cnt;

    id_ex_issue #(
        .DataSize(DW), .ALUopSize(AW), .RegAddrSize(RW), .StallCntSize(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_alu_type(in_alu_type), .in_rd(in_rd), .in_is_load(in_is_load),
        .flush(flush),
        .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wen(mwb_wen), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .src1(src1), .src2(src2), .ALUType(ALUType),
        .out_rd(out_rd), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus vectors ----------------
    typedef struct packed {
        logic          v;
        logic [RW-1:0] rs1, rs2, rd;
        logic [DW-1:0] d1, d2, imm;
        logic          ui;
        logic [AW-1:0] alu;
        logic          ld;
        logic          fl;
        logic          ew;
        logic [RW-1:0] erd;
        logic [DW-1:0] ed;
        logic          mw;
        logic [RW-1:0] mrd;
        logic [DW-1:0] md;
        logic          ordy;
    } vec_t;

    function automatic vec_t idle();
        vec_t x;
        x = '0;
        x.ordy = 1'b1;
        return x;
    endfunction

    function automatic vec_t ins(input int rs1, input int d1, input int rs2,
                                 input int d2, input int alu, input int rd);
        vec_t x;
        x = idle();
        x.v = 1'b1;
        x.rs1 = RW'(rs1); x.d1 = DW'(d1);
        x.rs2 = RW'(rs2); x.d2 = DW'(d2);
        x.alu = AW'(alu); x.rd = RW'(rd);
        return x;
    endfunction

    // Drive one cycle's inputs just after the edge, return at the negedge.
    task automatic cyc(input vec_t x);
        @(posedge clk);
        #1;
        in_valid = x.v; in_rs1 = x.rs1; in_rs2 = x.rs2; in_rd = x.rd;
        in_rs1_data = x.d1; in_rs2_data = x.d2; in_imm = x.imm;
        in_use_imm = x.ui; in_alu_type = x.alu; in_is_load = x.ld;
        flush = x.fl;
        exm_wen = x.ew; exm_rd = x.erd; exm_data = x.ed;
        mwb_wen = x.mw; mwb_rd = x.mrd; mwb_data = x.md;
        out_ready = x.ordy;
        @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          v;
        logic [RW-1:0] rs1, rs2, rd;
        logic [DW-1:0] d1, d2, imm;
        logic          ui;
        logic [AW-1:0] alu;
        logic          ld;
    } held_t;

    held_t m;
    int    m_cnt;

    // Registers whose new value the incoming instruction cannot yet obtain.
    function automatic bit exp_hazard();
        logic [RW-1:0] busy[$];
`ifdef FWD_EN
        if (m.v && m.ld) busy.push_back(m.rd);
`else
        if (m.v) busy.push_back(m.rd);
        if (exm_wen) busy.push_back(exm_rd);
        if (mwb_wen) busy.push_back(mwb_rd);
`endif
        foreach (busy[i])
            if (busy[i] != 0 && (busy[i] == in_rs1 || (!in_use_imm && busy[i] == in_rs2)))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_ready();
        return !flush && !exp_hazard() && (!m.v || out_ready);
    endfunction

`ifdef FWD_EN
    function automatic logic [DW-1:0] newest(input logic [RW-1:0] idx, input logic [DW-1:0] regval);
        if (idx == 0) return regval;
        if (exm_wen && exm_rd == idx) return exm_data;
        if (mwb_wen && mwb_rd == idx) return mwb_data;
        return regval;
    endfunction
    function automatic logic [DW-1:0] exp_src1();
        return newest(m.rs1, m.d1);
    endfunction
    function automatic logic [DW-1:0] exp_src2();
        return m.ui ? m.imm : newest(m.rs2, m.d2);
    endfunction
`else
    function automatic logic [DW-1:0] exp_src1();
        return m.d1;
    endfunction
    function automatic logic [DW-1:0] exp_src2();
        return m.ui ? m.imm : m.d2;
    endfunction
`endif

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m     <= '0;
            m_cnt <= 0;
        end else begin
            if (in_valid && exp_hazard() && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
            if (flush) begin
                m.v <= 1'b0;
            end else if (in_valid && exp_ready()) begin
                m.v <= 1'b1; m.rs1 <= in_rs1; m.rs2 <= in_rs2; m.rd <= in_rd;
                m.d1 <= in_rs1_data; m.d2 <= in_rs2_data; m.imm <= in_imm;
                m.ui <= in_use_imm; m.alu <= in_alu_type; m.ld <= in_is_load;
            end else if (out_ready) begin
                m.v <= 1'b0;
            end
        end
    end

    // One compare process: every cycle out of reset.
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready()));
            chk("out_valid", 32'(out_valid), 32'(m.v));
            chk("ALUType", 32'(ALUType), m.v ? 32'(m.alu) : 32'd8);
            chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
            if (m.v) begin
                chk("src1", src1, exp_src1());
                chk("src2", src2, exp_src2());
                chk("out_rd", 32'(out_rd), 32'(m.rd));
                chk("out_is_load", 32'(out_is_load), 32'(m.ld));
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        vec_t x;
        #1 rst = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_ALUType", 32'(ALUType), 8);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // ADD r3 = r1 + r2
        cyc(ins(1, 'h5, 2, 'h7, 0, 3));
        chk("add_in_ready", 32'(in_ready), 1);
        // SUB r4 = r3 - r1 (r3 not yet written back)
        cyc(ins(3, 0, 1, 'h5, 1, 4));
        chk("add_src1", src1, 'h5);
        chk("add_src2", src2, 'h7);
        chk("sub_raw_ready", 32'(in_ready), FWD ? 1 : 0);
        x = ins(3, 0, 1, 'h5, 1, 4); x.ew = 1; x.erd = 3; x.ed = 'h10;
        cyc(x);
        if (FWD) chk("sub_fwd_exm", src1, 'h10);
        else     chk("sub_bubble", 32'(out_valid), 0);
        x = ins(3, 0, 1, 'h5, 1, 4); x.mw = 1; x.mrd = 3; x.md = 'h10;
        cyc(x);
        cyc(ins(3, 'h10, 1, 'h5, 1, 4));
        chk("sub_stall_cnt", 32'(stall_cnt), FWD ? 0 : 3);
        cyc(idle());
        chk("sub_src1", src1, 'h10);
        chk("sub_src2", src2, 'h5);
        chk("sub_ALUType", 32'(ALUType), 1);
        chk("sub_out_rd", 32'(out_rd), 4);

        // EX/MEM over MEM/WB priority on a held rs1=5
        cyc(ins(5, 'h1, 6, 'h2, 4, 7));
        x = idle(); x.ordy = 0; x.ew = 1; x.erd = 5; x.ed = 'hA; x.mw = 1; x.mrd = 5; x.md = 'hB;
        cyc(x);
        chk("prio_src1", src1, FWD ? 'hA : 'h1);
        chk("prio_src2", src2, 'h2);
        x = idle(); x.ordy = 0; x.mw = 1; x.mrd = 5; x.md = 'hB;
        cyc(x);
        chk("mwb_src1", src1, FWD ? 'hB : 'h1);

        // LOAD r7 = [r1 + 4], then ADD r8 = r7 + r2
        x = ins(1, 'h100, 0, 0, 0, 7); x.ui = 1; x.imm = 'h4; x.ld = 1;
        cyc(x);
        cyc(ins(7, 0, 2, 'h7, 0, 8));
        chk("ld_src1", src1, 'h100);
        chk("ld_src2_imm", src2, 'h4);
        chk("ld_is_load", 32'(out_is_load), 1);
        chk("ld_use_ready", 32'(in_ready), 0);
        x = ins(7, 0, 2, 'h7, 0, 8); x.ew = 1; x.erd = 7; x.ed = 'h55;
        cyc(x);
        chk("ld_bubble", 32'(out_valid), 0);
        chk("ld_stall_cnt", 32'(stall_cnt), FWD ? 1 : 4);
        x = ins(7, 0, 2, 'h7, 0, 8); x.mw = 1; x.mrd = 7; x.md = 'h55;
        cyc(x);
        if (FWD) chk("ld_fwd_src1", src1, 'h55);
        cyc(ins(7, 'h55, 2, 'h7, 0, 8));
        chk("ld_stall_total", 32'(stall_cnt), FWD ? 1 : 6);
        x = idle(); x.ordy = 0;
        cyc(x);
        chk("add8_src1", src1, 'h55);
        chk("add8_src2", src2, 'h7);

        // back-pressure for three cycles, then flush
        for (int i = 0; i < 3; i++) begin
            x = ins(9, 'h9, 10, 'hA, 6, 11); x.ordy = 0;
            cyc(x);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_src1", src1, 'h55);
            chk("hold_ALUType", 32'(ALUType), 0);
            chk("hold_out_rd", 32'(out_rd), 8);
        end
        x = ins(9, 'h9, 10, 'hA, 6, 11); x.ordy = 0; x.fl = 1;
        cyc(x);
        chk("flush_in_ready", 32'(in_ready), 0);
        cyc(idle());
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_ALUType", 32'(ALUType), 8);

        // writers targeting r0 never forward
        x = ins(0, 0, 0, 0, 0, 0); x.ew = 1; x.erd = 0; x.ed = 'hFFFF;
        cyc(x);
        chk("r0_in_ready", 32'(in_ready), 1);
        x = idle(); x.ordy = 0; x.ew = 1; x.erd = 0; x.ed = 'hFFFF; x.mw = 1; x.mrd = 0; x.md = 'hFFFF;
        cyc(x);
        chk("r0_src1", src1, 0);

        // RAW on r2 through the writeback path
        x = ins(2, 'h2, 3, 'h3, 0, 1); x.ew = 1; x.erd = 2; x.ed = 'h22;
        cyc(x);
        chk("r2_exm_ready", 32'(in_ready), FWD ? 1 : 0);
        x = ins(2, 'h2, 3, 'h3, 0, 1); x.mw = 1; x.mrd = 2; x.md = 'h22;
        cyc(x);
        chk("r2_mwb_ready", 32'(in_ready), FWD ? 1 : 0);
        cyc(ins(2, 'h22, 3, 'h3, 0, 1));
        chk("r2_done_ready", 32'(in_ready), 1);
        chk("r2_stall_cnt", 32'(stall_cnt), FWD ? 1 : 8);

        // reset while an instruction is held
        cyc(idle());
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ALUType", 32'(ALUType), 8);
        chk("mid_rst_stall", 32'(stall_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // counter saturation: a stuck load with a dependent waiting behind it
        x = ins(1, 'h1, 0, 0, 0, 9); x.ld = 1;
        cyc(x);
        for (int i = 1; i <= 20; i++) begin
            x = ins(9, 0, 3, 'h3, 0, 10); x.ordy = 0;
            cyc(x);
            if (i == 10) chk("sat_mid", 32'(stall_cnt), 9);
        end
        x = idle(); x.ordy = 0;
        cyc(x);
        chk("sat_final", 32'(stall_cnt), 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
